// File: rtl/pet_stats_engine.sv
// pet_stats_engine: saturating pet stat counters with self-timed decay ticks,
// derived health, sleep recovery and a valid/ready command port.
module pet_stats_engine #(
    parameter int NUM_STATS = 5,
    parameter int STAT_W    = 5,
    parameter int TICK_DIV  = 10_000_000,
    parameter int IDX_W     = $clog2(NUM_STATS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    random,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [2:0]                    cmd_op,
    input  logic [IDX_W-1:0]              cmd_idx,
    input  logic [STAT_W-1:0]             cmd_amt,
    output logic [NUM_STATS*STAT_W-1:0]   stats_flat,
    output logic [NUM_STATS-1:0]          low_flags,
    output logic                          tick,
    output logic                          is_sleeping,
    output logic                          is_dead
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [STAT_W-1:0] MAX  = '1;
    localparam logic [STAT_W-1:0] HALF = {1'b1, {(STAT_W-1){1'b0}}};
    localparam logic [STAT_W-1:0] LOW  = MAX >> 2;
    localparam logic [STAT_W-1:0] ONE  = STAT_W'(1);
    localparam logic [2:0] OP_ADD = 3'd1, OP_SUB = 3'd2, OP_SLEEP = 3'd3, OP_WAKE = 3'd4, OP_REVIVE = 3'd5;

    typedef enum logic [1:0] {AWAKE, SLEEPING, DEAD} state_t;

    state_t            state_q, state_d;
    logic [STAT_W-1:0] stats_q [NUM_STATS];
    logic [STAT_W-1:0] stats_d [NUM_STATS];
    logic [PW-1:0]     pre_q;
    logic              tick_q;
    logic              tick_fire, accept, any_zero, all_half, idx_ok;
    logic [STAT_W-1:0] cur, add_v, sub_v, hp;
    logic [STAT_W:0]   sum;

    assign tick_fire   = pre_q == PW'(TICK_DIV - 1);
    assign cmd_ready   = !tick_fire;
    assign accept      = cmd_valid && cmd_ready;
    assign tick        = tick_q;
    assign is_sleeping = state_q == SLEEPING;
    assign is_dead     = state_q == DEAD;

    for (genvar g = 0; g < NUM_STATS; g++) begin : g_out
        assign stats_flat[g*STAT_W +: STAT_W] = stats_q[g];
        assign low_flags[g] = stats_q[g] <= LOW;
    end

    // Shared datapath: addressed stat, saturating add/sub, and health judged on pre-decay stats.
    always_comb begin
        cur      = '0;
        idx_ok   = 1'b0;
        any_zero = 1'b0;
        all_half = 1'b1;
        for (int i = 0; i < NUM_STATS; i++) begin
            if (cmd_idx == IDX_W'(i)) begin
                cur    = stats_q[i];
                idx_ok = 1'b1;
            end
        end
        for (int i = 1; i < NUM_STATS; i++) begin
            any_zero = any_zero | (stats_q[i] == '0);
            all_half = all_half & (stats_q[i] >= HALF);
        end
        sum   = {1'b0, cur} + {1'b0, cmd_amt};
        add_v = sum[STAT_W] ? MAX : sum[STAT_W-1:0];
        sub_v = cur > cmd_amt ? cur - cmd_amt : '0;
        hp    = any_zero ? (stats_q[0] == '0 ? '0 : stats_q[0] - ONE)
              : (all_half && stats_q[0] != MAX) ? stats_q[0] + ONE : stats_q[0];
    end

    always_comb begin
        state_d = state_q;
        stats_d = stats_q;
        if (tick_fire) begin
            if (state_q == AWAKE) begin
                for (int i = 1; i < NUM_STATS; i++)
                    stats_d[i] = (random[3'(i % 8)] && stats_q[i] != '0) ? stats_q[i] - ONE : stats_q[i];
                stats_d[0] = hp;
                if (hp == '0) state_d = DEAD;
            end else if (state_q == SLEEPING) begin
                stats_d[NUM_STATS-1] = stats_q[NUM_STATS-1] == MAX ? MAX : stats_q[NUM_STATS-1] + ONE;
                if (stats_d[NUM_STATS-1] == MAX) state_d = AWAKE;
            end
        end else if (accept) begin
            if (state_q == AWAKE) begin
                for (int i = 0; i < NUM_STATS; i++) begin
                    if (cmd_idx == IDX_W'(i)) begin
                        stats_d[i] = cmd_op == OP_ADD ? add_v : cmd_op == OP_SUB ? sub_v : stats_q[i];
                    end
                end
                if (cmd_op == OP_SUB && idx_ok && cmd_idx == '0 && sub_v == '0) state_d = DEAD;
                if (cmd_op == OP_SLEEP) state_d = SLEEPING;
            end else if (state_q == SLEEPING) begin
                if (cmd_op == OP_WAKE) state_d = AWAKE;
            end else if (cmd_op == OP_REVIVE) begin
                for (int i = 0; i < NUM_STATS; i++) stats_d[i] = HALF;
                state_d = AWAKE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= AWAKE;
            pre_q   <= '0;
            tick_q  <= 1'b0;
            for (int i = 0; i < NUM_STATS; i++) stats_q[i] <= HALF;
        end else begin
            state_q <= state_d;
            pre_q   <= tick_fire ? '0 : pre_q + PW'(1);
            tick_q  <= tick_fire;
            for (int i = 0; i < NUM_STATS; i++) stats_q[i] <= stats_d[i];
        end
    end
endmodule

// File: tb/tb_pet_stats_engine.sv
// tb_pet_stats_engine: directed checks of reset, commands, decay, health, sleep and death
// with a 4-cycle tick period.
module tb_pet_stats_engine;
    localparam int N = 5, W = 5, D = 4, IW = 3;

    logic           clk = 1'b0;
    logic           reset, cmd_valid, cmd_ready, tick, is_sleeping, is_dead;
    logic [7:0]     random;
    logic [2:0]     cmd_op;
    logic [IW-1:0]  cmd_idx;
    logic [W-1:0]   cmd_amt;
    logic [N*W-1:0] stats_flat;
    logic [N-1:0]   low_flags;
    int total = 0;
    int bad = 0;

    pet_stats_engine #(.NUM_STATS(N), .STAT_W(W), .TICK_DIV(D)) dut (
        .clk(clk), .reset(reset), .random(random), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_idx(cmd_idx), .cmd_amt(cmd_amt), .stats_flat(stats_flat),
        .low_flags(low_flags), .tick(tick), .is_sleeping(is_sleeping), .is_dead(is_dead)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int s0, input int s1, input int s2, input int s3, input int s4);
        return {7'd0, 5'(s4), 5'(s3), 5'(s2), 5'(s1), 5'(s0)};
    endfunction

    task automatic rst();
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 3'd0;
        cmd_idx = '0;
        cmd_amt = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic cmd(input logic [2:0] op, input logic [IW-1:0] idx, input logic [W-1:0] amt);
        if (!cmd_ready) step();
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_idx = idx;
        cmd_amt = amt;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic tick_now();
        int n = 0;
        while (cmd_ready && n < 8) begin
            step();
            n++;
        end
        if (cmd_ready) begin
            total++;
            bad++;
            $error("FAIL tick_timeout observed=%0d expected=0", cmd_ready);
        end
        step();
    endtask

    initial begin
        random = 8'h00;
        rst();
        chk("rst_stats", 32'(stats_flat), pk(16, 16, 16, 16, 16));
        chk("rst_low", 32'(low_flags), 32'h0);
        chk("rst_sleep", 32'(is_sleeping), 32'h0);
        chk("rst_dead", 32'(is_dead), 32'h0);
        for (int c = 0; c < 8; c++) begin
            chk("idle_ready", 32'(cmd_ready), 32'((c % 4) != 3));
            chk("idle_tick", 32'(tick), 32'((c % 4) == 0 && c > 0));
            step();
        end

        rst();
        cmd(3'd1, 3'd1, 5'd20);
        cmd(3'd2, 3'd2, 5'd20);
        cmd(3'd1, 3'd7, 5'd5);
        chk("cmd_stats", 32'(stats_flat), pk(16, 31, 0, 16, 16));
        chk("cmd_low", 32'(low_flags), 32'h04);
        chk("fire_ready", 32'(cmd_ready), 32'h0);

        rst();
        random = 8'hFF;
        tick_now();
        chk("decay1", 32'(stats_flat), pk(17, 15, 15, 15, 15));
        chk("decay1_tick", 32'(tick), 32'h1);
        tick_now();
        chk("decay2", 32'(stats_flat), pk(17, 14, 14, 14, 14));
        rst();
        random = 8'h12;
        tick_now();
        chk("decay_sel", 32'(stats_flat), pk(17, 15, 16, 16, 15));
        rst();
        random = 8'h00;
        tick_now();
        chk("health_up", 32'(stats_flat), pk(17, 16, 16, 16, 16));

        rst();
        cmd(3'd2, 3'd3, 5'd31);
        cmd(3'd2, 3'd0, 5'd14);
        chk("hp_set", 32'(stats_flat), pk(2, 16, 16, 0, 16));
        tick_now();
        chk("hp_down", 32'(stats_flat), pk(1, 16, 16, 0, 16));
        chk("alive", 32'(is_dead), 32'h0);
        tick_now();
        chk("hp_zero", 32'(stats_flat), pk(0, 16, 16, 0, 16));
        chk("dead", 32'(is_dead), 32'h1);
        cmd(3'd1, 3'd1, 5'd5);
        chk("dead_add", 32'(stats_flat), pk(0, 16, 16, 0, 16));
        random = 8'hFF;
        tick_now();
        chk("dead_tick", 32'(tick), 32'h1);
        chk("dead_frozen", 32'(stats_flat), pk(0, 16, 16, 0, 16));
        cmd(3'd5, 3'd0, 5'd0);
        chk("revive", 32'(stats_flat), pk(16, 16, 16, 16, 16));
        chk("revive_dead", 32'(is_dead), 32'h0);
        rst();
        cmd(3'd2, 3'd0, 5'd20);
        chk("sub_kill", 32'(is_dead), 32'h1);
        chk("sub_kill_hp", 32'(stats_flat), pk(0, 16, 16, 16, 16));

        rst();
        random = 8'h00;
        cmd(3'd1, 3'd4, 5'd13);
        cmd(3'd3, 3'd0, 5'd0);
        cmd(3'd1, 3'd1, 5'd3);
        chk("sleeping", 32'(is_sleeping), 32'h1);
        chk("sleep_add", 32'(stats_flat), pk(16, 16, 16, 16, 29));
        random = 8'hFF;
        tick_now();
        chk("sleep_e30", 32'(stats_flat), pk(16, 16, 16, 16, 30));
        chk("still_sleep", 32'(is_sleeping), 32'h1);
        tick_now();
        chk("sleep_e31", 32'(stats_flat), pk(16, 16, 16, 16, 31));
        chk("auto_wake", 32'(is_sleeping), 32'h0);
        rst();
        cmd(3'd3, 3'd0, 5'd0);
        cmd(3'd4, 3'd0, 5'd0);
        chk("wake", 32'(is_sleeping), 32'h0);

        rst();
        random = 8'h00;
        step();
        step();
        step();
        cmd_valid = 1'b1;
        cmd_op = 3'd1;
        cmd_idx = 3'd1;
        cmd_amt = 5'd5;
        chk("held_ready", 32'(cmd_ready), 32'h0);
        step();
        chk("held_tick", 32'(stats_flat), pk(17, 16, 16, 16, 16));
        chk("held_tickpulse", 32'(tick), 32'h1);
        chk("held_ready2", 32'(cmd_ready), 32'h1);
        step();
        cmd_valid = 1'b0;
        chk("held_apply", 32'(stats_flat), pk(17, 21, 16, 16, 16));
        step();
        chk("held_once", 32'(stats_flat), pk(17, 21, 16, 16, 16));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
